// File: rtl/pim_result_buffer.sv
// Indexed result buffer between PIM macro output stage and controller read path.
// Optional accumulate mode enabled by defining PIM_RESULT_ACC_EN.
module pim_result_buffer #(
  parameter int DEPTH  = 256,
  parameter int DATA_W = 32,
  parameter int IDX_W  = 8
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              i_clear,
  input  logic              i_wr_valid,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_acc_mode,
  input  logic              i_rd_en,
  input  logic [IDX_W-1:0]  i_rd_index,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_result_ready,
  output logic [IDX_W:0]    o_wr_count,
  output logic [1:0]        o_state,
  output logic              o_overflow
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FILL  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  valid;
  logic [IDX_W-1:0]  wr_addr;
  logic [DATA_W-1:0] wr_word;
  logic              is_full;
  logic              mem_we;
  logic              last_wr;
  logic              rd_done;
  logic              keep_valid;

  assign wr_addr    = o_wr_count[IDX_W-1:0];
  assign is_full    = (state == FULL);
  assign mem_we     = RSTN && !i_clear && i_wr_valid && !is_full;
  assign last_wr    = (wr_addr == IDX_W'(DEPTH-1));
  assign rd_done    = is_full && i_rd_en
                   && (i_rd_index == IDX_W'(DEPTH-1));
  assign o_state    = state;

`ifdef PIM_RESULT_ACC_EN
  logic                     acc_hit;
  logic signed [DATA_W:0]   sum;

  assign acc_hit = i_acc_mode && valid[wr_addr];
  assign sum     = $signed({mem[wr_addr][DATA_W-1], mem[wr_addr]})
                 + $signed({i_wr_data[DATA_W-1], i_wr_data});

  // Saturate when the carry-out disagrees with the sign bit
  always_comb begin
    wr_word = i_wr_data;
    if (acc_hit) begin
      if (sum[DATA_W] != sum[DATA_W-1])
        wr_word = {sum[DATA_W], {(DATA_W-1){~sum[DATA_W]}}};
      else
        wr_word = sum[DATA_W-1:0];
    end
  end

  assign keep_valid = i_acc_mode;
`else
  logic unused_acc;

  assign unused_acc = i_acc_mode;
  assign wr_word    = i_wr_data;
  assign keep_valid = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (mem_we)
      mem[wr_addr] <= wr_word;
  end

  always_ff @(posedge CLK) begin
    if (!RSTN || i_clear) begin
      state          <= EMPTY;
      o_wr_count     <= '0;
      valid          <= '0;
      o_result_ready <= 1'b0;
      o_overflow     <= 1'b0;
      if (!RSTN)
        o_rd_data <= '0;
    end else begin
      o_result_ready <= 1'b0;
      if (i_rd_en)
        o_rd_data <= valid[i_rd_index] ? mem[i_rd_index] : '0;
      if (i_wr_valid) begin
        if (is_full) begin
          o_overflow <= 1'b1;
        end else begin
          valid[wr_addr] <= 1'b1;
          o_wr_count     <= o_wr_count + 1'b1;
          state          <= last_wr ? FULL : FILL;
          o_result_ready <= last_wr;
        end
      end
      // Final read-out frees the frame; write above is dropped when FULL
      if (rd_done) begin
        state      <= EMPTY;
        o_wr_count <= '0;
        if (!keep_valid)
          valid <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pim_result_buffer.sv
// Self-checking bench for pim_result_buffer with a behavioural frame model.
// Accumulate tests run when PIM_RESULT_ACC_EN is defined.
module tb_pim_result_buffer;
  localparam int DEPTH  = 256;
  localparam int DATA_W = 32;
  localparam int IDX_W  = 8;
`ifdef PIM_RESULT_ACC_EN
  localparam bit ACC = 1'b1;
`else
  localparam bit ACC = 1'b0;
`endif

  logic              CLK = 1'b0;
  logic              RSTN;
  logic              i_clear;
  logic              i_wr_valid;
  logic [DATA_W-1:0] i_wr_data;
  logic              i_acc_mode;
  logic              i_rd_en;
  logic [IDX_W-1:0]  i_rd_index;
  logic [DATA_W-1:0] o_rd_data;
  logic              o_result_ready;
  logic [IDX_W:0]    o_wr_count;
  logic [1:0]        o_state;
  logic              o_overflow;

  always #5 CLK = ~CLK;

  pim_result_buffer #(
    .DEPTH(DEPTH), .DATA_W(DATA_W), .IDX_W(IDX_W)
  ) dut (
    .CLK(CLK), .RSTN(RSTN), .i_clear(i_clear),
    .i_wr_valid(i_wr_valid), .i_wr_data(i_wr_data),
    .i_acc_mode(i_acc_mode), .i_rd_en(i_rd_en),
    .i_rd_index(i_rd_index), .o_rd_data(o_rd_data),
    .o_result_ready(o_result_ready), .o_wr_count(o_wr_count),
    .o_state(o_state), .o_overflow(o_overflow)
  );

  // Behavioural model: a frame is a count of words plus a word array
  logic [31:0]      m_mem [DEPTH];
  bit [DEPTH-1:0]   m_valid;
  int               m_cnt;
  logic [31:0]      m_rd;
  bit               m_rdy;
  bit               m_ovf;
  int               n_err = 0;
  int               n_chk = 0;
  bit               chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b);
    longint s;
    s = longint'($signed(a)) + longint'($signed(b));
    if (s > 64'sd2147483647) return 32'h7FFF_FFFF;
    if (s < -64'sd2147483648) return 32'h8000_0000;
    return s[31:0];
  endfunction

  function automatic int exp_state();
    if (m_cnt == 0) return 0;
    if (m_cnt == DEPTH) return 2;
    return 1;
  endfunction

  task automatic model_update();
    bit full;
    bit done;
    int a;
    if (!RSTN) begin
      m_rd = 0; m_rdy = 0; m_cnt = 0; m_ovf = 0; m_valid = '0;
      return;
    end
    if (i_clear) begin
      m_rdy = 0; m_cnt = 0; m_ovf = 0; m_valid = '0;
      return;
    end
    full = (m_cnt == DEPTH);
    done = full && i_rd_en && (int'(i_rd_index) == DEPTH - 1);
    if (i_rd_en)
      m_rd = m_valid[i_rd_index] ? m_mem[i_rd_index] : 32'h0;
    m_rdy = 0;
    if (i_wr_valid) begin
      if (full) begin
        m_ovf = 1;
      end else begin
        a = m_cnt;
        if (ACC && i_acc_mode && m_valid[a])
          m_mem[a] = sat_add(m_mem[a], i_wr_data);
        else
          m_mem[a] = i_wr_data;
        m_valid[a] = 1'b1;
        m_cnt++;
        if (m_cnt == DEPTH) m_rdy = 1;
      end
    end
    if (done) begin
      m_cnt = 0;
      if (!(ACC && i_acc_mode)) m_valid = '0;
    end
  endtask

  always @(negedge CLK) begin
    if (chk_en) begin
      chk("rd_data", o_rd_data, m_rd);
      chk("result_ready", o_result_ready, m_rdy);
      chk("wr_count", o_wr_count, m_cnt);
      chk("state", o_state, exp_state());
      chk("overflow", o_overflow, m_ovf);
    end
  end

  task automatic tick();
    @(posedge CLK);
    model_update();
    @(negedge CLK);
  endtask

  task automatic drive(input bit w, input logic [31:0] d,
                       input bit r, input logic [7:0] ix);
    i_wr_valid = w; i_wr_data = d; i_rd_en = r; i_rd_index = ix;
    tick();
  endtask

  task automatic frame(input logic [31:0] base, input bit add_idx);
    for (int i = 0; i < DEPTH; i++)
      drive(1'b1, add_idx ? base + 32'(i) : base, 1'b0, 8'd0);
  endtask

  task automatic readout();
    for (int i = 0; i < DEPTH; i++)
      drive(1'b0, 32'h0, 1'b1, 8'(i));
  endtask

  initial begin
    RSTN = 1'b0; i_clear = 1'b0; i_wr_valid = 1'b0; i_wr_data = '0;
    i_acc_mode = 1'b0; i_rd_en = 1'b0; i_rd_index = '0;
    @(negedge CLK);
    tick();
    chk_en = 1'b1;
    tick();
    chk("rst_rd_data", o_rd_data, 0);
    chk("rst_state", o_state, 0);
    chk("rst_count", o_wr_count, 0);
    RSTN = 1'b1;

    // Full frame; ready pulse only after the last write
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 32'h100 + 32'(i), 1'b0, 8'd0);
      if (i < DEPTH - 1) chk("ready_early", o_result_ready, 0);
    end
    chk("ready_pulse", o_result_ready, 1);
    chk("full_state", o_state, 2);
    chk("full_count", o_wr_count, 256);
    chk("full_ovf", o_overflow, 0);
    drive(1'b1, 32'hDEAD, 1'b0, 8'd0);
    chk("ready_drop", o_result_ready, 0);
    chk("ovf_set", o_overflow, 1);
    drive(1'b0, 32'h0, 1'b1, 8'd0);
    chk("word0_kept", o_rd_data, 32'h100);

    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 32'h0, 1'b1, 8'(i));
      chk("readout", o_rd_data, 32'h100 + 32'(i));
    end
    chk("done_state", o_state, 0);
    chk("done_count", o_wr_count, 0);

    // Partial frame reads
    for (int i = 0; i < 10; i++)
      drive(1'b1, 32'h100 + 32'(i), 1'b0, 8'd0);
    drive(1'b0, 32'h0, 1'b1, 8'd20);
    chk("rd_invalid", o_rd_data, 0);
    drive(1'b0, 32'h0, 1'b1, 8'd5);
    chk("rd_5", o_rd_data, 32'h105);
    chk("fill_state", o_state, 1);

    // Clear wins over a simultaneous write and keeps rd_data
    i_clear = 1'b1;
    drive(1'b1, 32'h1234, 1'b0, 8'd0);
    i_clear = 1'b0;
    chk("clr_state", o_state, 0);
    chk("clr_count", o_wr_count, 0);
    chk("clr_ovf", o_overflow, 0);
    chk("clr_rd_hold", o_rd_data, 32'h105);
    drive(1'b0, 32'h0, 1'b1, 8'd0);
    chk("clr_nowrite", o_rd_data, 0);

    // Reset mid-fill then a clean frame
    for (int i = 0; i < 100; i++)
      drive(1'b1, 32'h100 + 32'(i), 1'b0, 8'd0);
    drive(1'b0, 32'h0, 1'b1, 8'd50);
    chk("rd_50", o_rd_data, 32'h132);
    RSTN = 1'b0;
    drive(1'b1, 32'h55, 1'b0, 8'd0);
    RSTN = 1'b1;
    chk("mrst_rd", o_rd_data, 0);
    chk("mrst_count", o_wr_count, 0);
    chk("mrst_state", o_state, 0);
    frame(32'h200, 1'b1);
    chk("mrst_ready", o_result_ready, 1);
    chk("mrst_full", o_state, 2);
    readout();

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      RSTN = ($urandom_range(0, 299) != 0);
      i_clear = ($urandom_range(0, 149) == 0);
      i_acc_mode = 1'($urandom);
      drive(1'($urandom), $urandom, 1'($urandom),
            ($urandom_range(0, 3) == 0) ? 8'd255 : 8'($urandom));
    end
    RSTN = 1'b1; i_clear = 1'b0; i_acc_mode = 1'b0;

`ifdef PIM_RESULT_ACC_EN
    i_clear = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 8'd0);
    i_clear = 1'b0;
    i_acc_mode = 1'b1;
    frame(32'h7FFF_FFF0, 1'b0);
    readout();
    frame(32'h20, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 8'd7);
    chk("acc_sat", o_rd_data, 32'h7FFF_FFFF);
    readout();
    i_clear = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 8'd0);
    i_clear = 1'b0;
    frame(32'h5, 1'b0);
    readout();
    frame(32'h10, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 8'd3);
    chk("acc_sum", o_rd_data, 32'h15);
    i_acc_mode = 1'b0;
`endif

    drive(1'b0, 32'h0, 1'b0, 8'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
